cnn_core: RTL and testbench

Single-layer convolution engine for the LeNet-5 accelerator. It reads an 8-bit input feature map and six 3x3 kernels from two block RAMs, then writes six ReLU'd, requantized 7x7 output maps to a third block RAM. It runs under a start/done handshake from the top-level controller. The companion single-port memory model `bram` is part of this block's delivery.

---
 rtl/cnn_core.sv | 265 ++++++++++++++++++++++++++
 tb/tb_cnn_core.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_core.sv
// cnn_core: single-layer 3x3 convolution engine (LeNet-5 accelerator).
// Streams weights and feature-map pixels out of two read-only BRAMs,
// multiply-accumulates each window, applies ReLU plus shift/saturate
// requantization and writes one signed byte per output pixel to TEMP.
// Also contains `bram`, the single-port read-first memory model the core
// talks to.

module bram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  input  logic [7:0]        din,
  output logic [7:0]        dout
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [IDX_W-1:0] w_idx;
  logic             w_hit;

  // Out-of-range addresses neither write nor return stored data.
  assign w_idx = addr[IDX_W-1:0];
  assign w_hit = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);

  // Storage write port.
  // NOTE: the array has no reset branch; clearing RAM contents is neither
  // possible in block RAM nor wanted, so only the output register is reset.
  always_ff @(posedge clk) begin
    if (en && wen && w_hit) mem[w_idx] <= din;
  end

  // Registered read port, read-first, holds while disabled.
  // NOTE: non-blocking assignment is what makes this read-first: dout samples
  // mem before the same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dout <= '0;
    else if (en) dout <= w_hit ? mem[w_idx] : '0;
  end

endmodule

module cnn_core #(
  parameter int IMG    = 9,
  parameter int K      = 3,
  parameter int NCH    = 6,
  parameter int SHIFT  = 7,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,

  output logic [ADDR_W-1:0] BRAM_IF_ADDR,
  output logic              BRAM_IF_EN,
  output logic              BRAM_IF_WE,
  output logic              BRAM_IF_RST,
  output logic [7:0]        BRAM_IF_DIN,
  input  logic [7:0]        BRAM_IF_DOUT,

  output logic [ADDR_W-1:0] BRAM_W_ADDR,
  output logic              BRAM_W_EN,
  output logic              BRAM_W_WE,
  output logic              BRAM_W_RST,
  output logic [7:0]        BRAM_W_DIN,
  input  logic [7:0]        BRAM_W_DOUT,

  output logic [ADDR_W-1:0] BRAM_TEMP_ADDR,
  output logic              BRAM_TEMP_EN,
  output logic              BRAM_TEMP_WE,
  output logic              BRAM_TEMP_RST,
  output logic [7:0]        BRAM_TEMP_DIN,
  input  logic [7:0]        BRAM_TEMP_DOUT
);

  localparam int OUT   = IMG - K + 1;
  localparam int KK    = K * K;
  localparam int CNT_W = $clog2(KK + 1);

  // Tap counter runs 0..KK: KK address issues, the last read captured at KK.
  localparam logic [CNT_W-1:0]  L_CNT_LAST = CNT_W'(KK);
  localparam logic [ADDR_W-1:0] L_K_LAST   = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] L_OUT_LAST = ADDR_W'(OUT - 1);
  localparam logic [ADDR_W-1:0] L_NCH_LAST = ADDR_W'(NCH - 1);
  localparam logic [ADDR_W-1:0] L_IMG      = ADDR_W'(IMG);
  localparam logic [ADDR_W-1:0] L_KK       = ADDR_W'(KK);
  localparam logic [ADDR_W-1:0] L_OUT      = ADDR_W'(OUT);
  localparam logic [ADDR_W-1:0] L_MAP      = ADDR_W'(OUT * OUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_MAC, S_WRITE, S_DONE
  } state_t;

  state_t                   r_state, w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic [ADDR_W-1:0]        r_k, r_oy, r_ox, r_ky, r_kx;
  logic signed [19:0]       r_acc;
  logic signed [7:0]        r_w [KK];

  logic                     w_issue, w_capture, w_last_tap, w_last_win, w_last_k;
  logic signed [15:0]       w_prod;
  logic signed [19:0]       w_shifted;
  logic [7:0]               w_result;
  logic                     w_unused;

  // Read-only ports and memory output resets are never exercised.
  assign BRAM_IF_WE    = 1'b0;
  assign BRAM_IF_DIN   = '0;
  assign BRAM_IF_RST   = 1'b0;
  assign BRAM_W_WE     = 1'b0;
  assign BRAM_W_DIN    = '0;
  assign BRAM_W_RST    = 1'b0;
  assign BRAM_TEMP_RST = 1'b0;
  // TEMP is write-only from the core's point of view.
  assign w_unused      = ^BRAM_TEMP_DOUT;

  assign w_issue    = (r_cnt != L_CNT_LAST);
  assign w_capture  = (r_cnt != '0);
  assign w_last_tap = (r_cnt == L_CNT_LAST);
  assign w_last_win = (r_ox == L_OUT_LAST) && (r_oy == L_OUT_LAST);
  assign w_last_k   = (r_k == L_NCH_LAST);

  // r_w[0] always holds the weight matching the pixel currently on IF_DOUT.
  assign w_prod    = $signed(BRAM_IF_DOUT) * r_w[0];
  assign w_shifted = r_acc >>> SHIFT;

  // ReLU, then shift and clamp to the positive int8 range.
  always_comb begin
    if (r_acc[19])                 w_result = 8'd0;
    else if (w_shifted > 20'sd127) w_result = 8'd127;
    else                           w_result = w_shifted[7:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic.
  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_LOAD_W;
      S_LOAD_W:       if (w_last_tap) w_next = S_MAC;
      S_MAC:          if (w_last_tap) w_next = S_WRITE;
      S_WRITE: begin
        if (w_last_win && w_last_k) w_next = S_DONE;
        else if (w_last_win)        w_next = S_LOAD_W;
        else                        w_next = S_MAC;
      end
      default:        w_next = S_IDLE;
    endcase
  end

  // FSM outputs: memory strobes and addresses, zero whenever idle.
  always_comb begin
    done           = (r_state == S_DONE);
    BRAM_IF_EN     = 1'b0;
    BRAM_IF_ADDR   = '0;
    BRAM_W_EN      = 1'b0;
    BRAM_W_ADDR    = '0;
    BRAM_TEMP_EN   = 1'b0;
    BRAM_TEMP_WE   = 1'b0;
    BRAM_TEMP_ADDR = '0;
    BRAM_TEMP_DIN  = '0;
    case (r_state)
      S_LOAD_W: if (w_issue) begin
        BRAM_W_EN   = 1'b1;
        BRAM_W_ADDR = r_k * L_KK + ADDR_W'(r_cnt);
      end
      S_MAC: if (w_issue) begin
        BRAM_IF_EN   = 1'b1;
        BRAM_IF_ADDR = (r_oy + r_ky) * L_IMG + r_ox + r_kx;
      end
      S_WRITE: begin
        BRAM_TEMP_EN   = 1'b1;
        BRAM_TEMP_WE   = 1'b1;
        BRAM_TEMP_ADDR = r_k * L_MAP + r_oy * L_OUT + r_ox;
        BRAM_TEMP_DIN  = w_result;
      end
      default: ;
    endcase
  end

  // Loop counters and accumulator: taps, window position, kernel index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_k   <= '0;
      r_oy  <= '0;
      r_ox  <= '0;
      r_ky  <= '0;
      r_kx  <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_cnt <= '0;
          r_k   <= '0;
          r_oy  <= '0;
          r_ox  <= '0;
        end
        S_LOAD_W: begin
          if (w_last_tap) begin
            r_cnt <= '0;
            r_ky  <= '0;
            r_kx  <= '0;
            r_acc <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MAC: begin
          if (w_issue) begin
            if (r_kx == L_K_LAST) begin
              r_kx <= '0;
              r_ky <= r_ky + 1'b1;
            end else begin
              r_kx <= r_kx + 1'b1;
            end
          end
          if (w_capture) r_acc <= r_acc + {{4{w_prod[15]}}, w_prod};
          r_cnt <= w_last_tap ? '0 : r_cnt + 1'b1;
        end
        S_WRITE: begin
          r_cnt <= '0;
          r_ky  <= '0;
          r_kx  <= '0;
          r_acc <= '0;
          if (r_ox == L_OUT_LAST) begin
            r_ox <= '0;
            if (r_oy == L_OUT_LAST) begin
              r_oy <= '0;
              r_k  <= r_k + 1'b1;
            end else begin
              r_oy <= r_oy + 1'b1;
            end
          end else begin
            r_ox <= r_ox + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight shift register: filled tap-by-tap in LOAD_W, rotated once per tap
  // in MAC so the next weight always sits at index 0.
  always_ff @(posedge clk) begin
    if (w_capture && (r_state == S_LOAD_W || r_state == S_MAC)) begin
      for (int i = 0; i < KK - 1; i++) r_w[i] <= r_w[i+1];
      r_w[KK-1] <= (r_state == S_LOAD_W) ? $signed(BRAM_W_DOUT) : r_w[0];
    end
  end

endmodule

// File: tb/tb_cnn_core.sv
// Directed bench for cnn_core with three bram instances. The bench loads
// memories through a side-port mux while the core is idle, runs whole jobs,
// and reads TEMP back hierarchically.

module tb_cnn_core;

  localparam int AW    = 16;
  localparam int NOUT  = 294;
  localparam int JOB   = 3294;
  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic done;

  logic [AW-1:0] if_addr, w_addr, t_addr;
  logic          if_en, w_en, t_en, if_we, w_we, t_we, if_rst, w_rst, t_rst;
  logic [7:0]    if_din, w_din, t_din, if_dout, w_dout, t_dout;

  // Bench side-port used to preload memories while the core is quiet.
  logic          ld_en   = 1'b0;
  logic [1:0]    ld_sel  = 2'd0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_din  = '0;

  int total = 0;
  int bad   = 0;
  int we_pulses = 0;

  always #5 clk = ~clk;

  cnn_core dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .BRAM_IF_ADDR(if_addr), .BRAM_IF_EN(if_en), .BRAM_IF_WE(if_we),
    .BRAM_IF_RST(if_rst), .BRAM_IF_DIN(if_din), .BRAM_IF_DOUT(if_dout),
    .BRAM_W_ADDR(w_addr), .BRAM_W_EN(w_en), .BRAM_W_WE(w_we),
    .BRAM_W_RST(w_rst), .BRAM_W_DIN(w_din), .BRAM_W_DOUT(w_dout),
    .BRAM_TEMP_ADDR(t_addr), .BRAM_TEMP_EN(t_en), .BRAM_TEMP_WE(t_we),
    .BRAM_TEMP_RST(t_rst), .BRAM_TEMP_DIN(t_din), .BRAM_TEMP_DOUT(t_dout)
  );

  bram u_if (
    .clk(clk), .rst(rst),
    .wen (ld_en ? (ld_sel == 2'd0) : if_we),
    .addr(ld_en ? ld_addr : if_addr),
    .en  (ld_en ? (ld_sel == 2'd0) : if_en),
    .din (ld_en ? ld_din : if_din),
    .dout(if_dout)
  );

  bram u_w (
    .clk(clk), .rst(rst),
    .wen (ld_en ? (ld_sel == 2'd1) : w_we),
    .addr(ld_en ? ld_addr : w_addr),
    .en  (ld_en ? (ld_sel == 2'd1) : w_en),
    .din (ld_en ? ld_din : w_din),
    .dout(w_dout)
  );

  bram u_temp (
    .clk(clk), .rst(rst),
    .wen (ld_en ? (ld_sel == 2'd2) : t_we),
    .addr(ld_en ? ld_addr : t_addr),
    .en  (ld_en ? (ld_sel == 2'd2) : t_en),
    .din (ld_en ? ld_din : t_din),
    .dout(t_dout)
  );

  always @(posedge clk) begin
    if (t_en && t_we) we_pulses <= we_pulses + 1;
  end

  // All bench tasks start and end 1 time unit after a rising edge.
  task automatic mem_write(input logic [1:0] sel, input int addr, input logic [7:0] val);
    ld_en = 1'b1; ld_sel = sel; ld_addr = AW'(addr); ld_din = val;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic fill(input logic [1:0] sel, input int n, input logic [7:0] val);
    for (int i = 0; i < n; i++) mem_write(sel, i, val);
  endtask

  // Pulse start, count edges until done; optionally re-pulse start mid-job.
  task automatic run_job(input int restart_at, output int cycles, output logic done0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done0 = done;
    cycles = 0;
    while (!done && cycles < LIMIT) begin
      if (cycles == restart_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({done, if_en, w_en, t_en, if_we, w_we, t_we, if_rst, w_rst, t_rst} !== 10'd0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0", {done, if_en, w_en, t_en, if_we, w_we, t_we});
    end
    total++;
    if ({if_addr, w_addr, t_addr} !== 48'd0) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=0", {if_addr, w_addr, t_addr});
    end
    total++;
    if ({if_din, w_din, t_din} !== 24'd0) begin
      bad++;
      $display("FAIL reset_din got=%h exp=0", {if_din, w_din, t_din});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // IF=2, W=64: every output is 9*128 >>> 7 = 9; also probes the access pattern.
  task automatic test_basic();
    int n;
    int pulses0;
    fill(2'd0, 81, 8'd2);
    fill(2'd1, 54, 8'd64);
    fill(2'd2, 300, 8'hAA);
    pulses0 = we_pulses;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < LIMIT) begin
      if (n == 0) begin
        total++;
        if ({w_en, w_addr} !== {1'b1, 16'd0}) begin
          bad++; $display("FAIL basic_w_first got=%0d/%0d exp=1/0", w_en, w_addr);
        end
      end
      if (n == 8) begin
        total++;
        if ({w_en, w_addr} !== {1'b1, 16'd8}) begin
          bad++; $display("FAIL basic_w_last got=%0d/%0d exp=1/8", w_en, w_addr);
        end
      end
      if (n == 9) begin
        total++;
        if ({w_en, if_en, t_en} !== 3'b000) begin
          bad++; $display("FAIL basic_capture_idle got=%b exp=000", {w_en, if_en, t_en});
        end
      end
      if (n == 10) begin
        total++;
        if ({if_en, if_addr} !== {1'b1, 16'd0}) begin
          bad++; $display("FAIL basic_if_first got=%0d/%0d exp=1/0", if_en, if_addr);
        end
      end
      if (n == 13) begin
        total++;
        if (if_addr !== 16'd9) begin
          bad++; $display("FAIL basic_if_row1 got=%0d exp=9", if_addr);
        end
      end
      if (n == 18) begin
        total++;
        if (if_addr !== 16'd20) begin
          bad++; $display("FAIL basic_if_tap8 got=%0d exp=20", if_addr);
        end
      end
      if (n == 20) begin
        total++;
        if ({t_en, t_we, t_addr, t_din} !== {1'b1, 1'b1, 16'd0, 8'd9}) begin
          bad++; $display("FAIL basic_write0 got=%0d/%0d/%0d/%0d exp=1/1/0/9", t_en, t_we, t_addr, t_din);
        end
      end
      if (n == 21) begin
        total++;
        if (if_addr !== 16'd1) begin
          bad++; $display("FAIL basic_win1 got=%0d exp=1", if_addr);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== JOB) begin
      bad++; $display("FAIL basic_latency got=%0d exp=%0d", n, JOB);
    end
    total++;
    if (we_pulses - pulses0 !== NOUT) begin
      bad++; $display("FAIL basic_we_count got=%0d exp=%0d", we_pulses - pulses0, NOUT);
    end
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (u_temp.mem[i] !== 8'd9) begin
        bad++; $display("FAIL basic_temp[%0d] got=%0d exp=9", i, u_temp.mem[i]);
      end
    end
    total++;
    if (u_temp.mem[NOUT] !== 8'hAA) begin
      bad++; $display("FAIL basic_past_end got=%h exp=aa", u_temp.mem[NOUT]);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({done, if_en, w_en, t_en} !== 4'b1000) begin
      bad++; $display("FAIL basic_done_hold got=%b exp=1000", {done, if_en, w_en, t_en});
    end
  endtask

  // 9*127*127 = 145161, >>>7 = 1134: saturates to 127.
  task automatic test_saturate();
    int cyc;
    logic d0;
    fill(2'd0, 81, 8'd127);
    fill(2'd1, 54, 8'd127);
    fill(2'd2, 300, 8'hAA);
    run_job(-1, cyc, d0);
    total++;
    if (cyc !== JOB) begin
      bad++; $display("FAIL sat_latency got=%0d exp=%0d", cyc, JOB);
    end
    total++;
    if (d0 !== 1'b0) begin
      bad++; $display("FAIL sat_done_drop got=%0d exp=0", d0);
    end
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (u_temp.mem[i] !== 8'd127) begin
        bad++; $display("FAIL sat_temp[%0d] got=%0d exp=127", i, u_temp.mem[i]);
      end
    end
  endtask

  // W=-1, IF=5: acc = -45, ReLU clamps to 0.
  task automatic test_relu();
    int cyc;
    int pulses0;
    logic d0;
    fill(2'd0, 81, 8'd5);
    fill(2'd1, 54, 8'hFF);
    fill(2'd2, 300, 8'hAA);
    pulses0 = we_pulses;
    run_job(-1, cyc, d0);
    total++;
    if (we_pulses - pulses0 !== NOUT) begin
      bad++; $display("FAIL relu_we_count got=%0d exp=%0d", we_pulses - pulses0, NOUT);
    end
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (u_temp.mem[i] !== 8'd0) begin
        bad++; $display("FAIL relu_temp[%0d] got=%0d exp=0", i, u_temp.mem[i]);
      end
    end
  endtask

  // IF[i]=i, centre weight 127: output = centre pixel * 127 >>> 7.
  task automatic test_pattern();
    int cyc;
    int v;
    int e;
    logic d0;
    for (int i = 0; i < 81; i++) mem_write(2'd0, i, 8'(i % 128));
    for (int i = 0; i < 54; i++) mem_write(2'd1, i, (i % 9 == 4) ? 8'd127 : 8'd0);
    fill(2'd2, 300, 8'hAA);
    run_job(-1, cyc, d0);
    for (int k = 0; k < 6; k++)
      for (int oy = 0; oy < 7; oy++)
        for (int ox = 0; ox < 7; ox++) begin
          v = ((oy + 1) * 9 + ox + 1) % 128;
          e = (v * 127) >>> 7;
          total++;
          if (u_temp.mem[k*49 + oy*7 + ox] !== 8'(e)) begin
            bad++;
            $display("FAIL pattern_temp[%0d] got=%0d exp=%0d", k*49 + oy*7 + ox,
                     u_temp.mem[k*49 + oy*7 + ox], e);
          end
        end
  endtask

  // start mid-job is ignored; start from DONE reruns with fresh IF (3*64*9>>>7=13).
  task automatic test_back_to_back();
    int cyc;
    logic d0;
    fill(2'd0, 81, 8'd2);
    fill(2'd1, 54, 8'd64);
    fill(2'd2, 300, 8'hAA);
    run_job(100, cyc, d0);
    total++;
    if (cyc !== JOB) begin
      bad++; $display("FAIL b2b_ignored_start got=%0d exp=%0d", cyc, JOB);
    end
    total++;
    if (u_temp.mem[NOUT-1] !== 8'd9) begin
      bad++; $display("FAIL b2b_first_last got=%0d exp=9", u_temp.mem[NOUT-1]);
    end
    fill(2'd0, 81, 8'd3);
    run_job(-1, cyc, d0);
    total++;
    if (d0 !== 1'b0) begin
      bad++; $display("FAIL b2b_done_drop got=%0d exp=0", d0);
    end
    total++;
    if (cyc !== JOB) begin
      bad++; $display("FAIL b2b_rerun_latency got=%0d exp=%0d", cyc, JOB);
    end
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (u_temp.mem[i] !== 8'd13) begin
        bad++; $display("FAIL b2b_temp[%0d] got=%0d exp=13", i, u_temp.mem[i]);
      end
    end
  endtask

  // rst mid-MAC aborts at once; a following job still completes correctly.
  task automatic test_reset_mid_job();
    int cyc;
    logic d0;
    fill(2'd2, 300, 8'hAA);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    total++;
    if (if_en !== 1'b1) begin
      bad++; $display("FAIL abort_in_mac got=%0d exp=1", if_en);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({done, if_en, w_en, t_en, t_we} !== 5'd0) begin
      bad++; $display("FAIL abort_async got=%b exp=00000", {done, if_en, w_en, t_en, t_we});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({done, if_en, w_en, t_en} !== 4'd0) begin
      bad++; $display("FAIL abort_idle got=%b exp=0000", {done, if_en, w_en, t_en});
    end
    total++;
    if (u_temp.mem[0] !== 8'hAA) begin
      bad++; $display("FAIL abort_no_write got=%h exp=aa", u_temp.mem[0]);
    end
    run_job(-1, cyc, d0);
    total++;
    if (cyc !== JOB) begin
      bad++; $display("FAIL abort_rerun_latency got=%0d exp=%0d", cyc, JOB);
    end
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (u_temp.mem[i] !== 8'd13) begin
        bad++; $display("FAIL abort_temp[%0d] got=%0d exp=13", i, u_temp.mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_relu();
    test_pattern();
    test_back_to_back();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
